mem_byte_lsu: RTL and testbench
===============================

# mem_byte_lsu

Load/store sequencer between the MEM pipeline stage and the byte-organised data memory. Accepts one load or store per request (byte, halfword, word), checks alignment, and sequences one byte per cycle to the memory port, most significant byte at the lowest address. Loads are assembled and sign- or zero-extended to 32 bits. The pipeline stalls on `busy`.

## Interface
Parameters:
- `ADDR_W`, default 32: address width of the pipeline and memory ports.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req`  in  1  request valid; held by the pipeline until accepted.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `sign_ext`  in  1  loads only: 1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu).
- `addr`  in  ADDR_W  byte address.
- `wdata`  in  32  store data; the low 1/2/4 bytes are used.
- `busy`  out  1  transfer in progress; the pipeline stalls.
- `done`  out  1  one-cycle completion pulse.
- `misalign`  out  1  one-cycle error pulse, coincident with `done`.
- `rdata`  out  32  last completed load result; held until the next load completes.
- `mem_read`  out  1  memory read enable.
- `mem_write`  out  1  memory write enable; the memory writes one byte on the rising edge.
- `mem_addr`  out  ADDR_W  memory byte address.
- `mem_wdata`  out  8  store byte.
- `mem_rdata`  in  8  read byte; combinational from `mem_addr`.

## Operation
- States: IDLE, XFER.
- IDLE:
  - Accept when `req`=1. Capture `we`, `size`, `sign_ext`, `addr` and `wdata`.
  - Set beat count N = 1/2/4 and beat index i = 0.
- Alignment error:
  - Error cases: `size`=01 with `addr[0]`=1, `size`=10 with `addr[1:0]`≠0, or `size`=11.
  - Stay in IDLE. Pulse `done` and `misalign` the next cycle.
  - No memory access occurs. `rdata` is unchanged.
- Legal request: go to XFER.
- XFER, beat i:
  - `mem_addr` = captured addr + i, modulo 2^ADDR_W (wraps).
  - Store: `mem_write`=1, `mem_wdata` = byte (N-1-i) of `wdata`, counting byte 0 as `wdata[7:0]`. This writes MSB first.
  - Load: `mem_read`=1. Shift register acc ← {acc[23:0], `mem_rdata`} at the edge.
- After beat N-1: return to IDLE and pulse `done`.
- Load result, loaded into `rdata` on the same edge:
  - Byte: sign- or zero-extend acc[7:0].
  - Halfword: sign- or zero-extend acc[15:0].
  - Word: acc[31:0].
  - The extension bit is taken from the final assembled value.
- Stores never modify `rdata`.
- Outside XFER: `mem_read`, `mem_write`, `mem_addr` and `mem_wdata` are all 0.
- `busy` = (state == XFER). `req` is ignored while busy.
- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE. All outputs are 0, including `rdata`=0.
  - Reset during XFER aborts the transfer. Bytes already written remain in memory. No `done` pulse is produced.

## Timing
- `req` sampled at edge k (IDLE) with a legal request:
  - Beats occupy cycles k+1 … k+N.
  - `busy` is high in those cycles.
  - `done` is high in cycle k+N+1, with `rdata` valid from the same cycle.
- Misaligned request at edge k: `done` and `misalign` are high in cycle k+1. `busy` never rises.
- The `done` cycle is IDLE, so a new `req` is accepted in it. Back-to-back throughput is N+1 cycles per access.
- A store byte is committed at the rising edge ending its beat cycle.
- A load byte is sampled at the rising edge ending its beat cycle.
- `done` and `misalign` are registered and never high for more than one cycle per request.

## Test plan
- **Store word:** sw `wdata`=0xAABBCCDD, `addr`=0x10 → over 4 beats memory gets [0x10]=AA, [0x11]=BB, [0x12]=CC, [0x13]=DD. `busy` high for 4 cycles, `done` in the 5th cycle after acceptance, `rdata` unchanged.
- **Load word:** lw 0x10 after the above → `rdata`=0xAABBCCDD, `done` 5 cycles after acceptance.
- **Sub-word loads:** from the same data:
  - lb 0x10 signed → 0xFFFFFFAA.
  - lbu 0x10 → 0x000000AA.
  - lh 0x12 signed → 0xFFFFCCDD.
  - lhu 0x12 → 0x0000CCDD.
  - lb 0x13 signed → 0xFFFFFFDD.
  - Byte loads take 2 cycles; halfword loads take 3.
- **Misalignment:** lw 0x11, lh 0x13, and `size`=11 → each gives `done`+`misalign` for one cycle. `mem_read`/`mem_write` stay 0 throughout. `rdata` is unchanged.
- **Reset mid-store:** sw 0x11223344 at 0x20, `rst_n`=0 sampled at the edge ending beat 1 → only [0x20]=11 and [0x21]=22 are written. All outputs go to 0, no `done` pulse. A following sb at 0x30 completes normally.
- **Back-to-back and wrap:**
  - `req` held high for sb 0x40 then sb 0x41 → second accepted in the first's `done` cycle; `done` pulses exactly 2 cycles apart.
  - sw at 0xFFFFFFFC → `mem_addr` sequence FC, FD, FE, FF with no carry into the next access.

Source files
------------

// File: rtl/mem_byte_lsu.sv
// mem_byte_lsu
//
// Load/store sequencer between the MEM pipeline stage and a byte-wide data
// memory. One request (byte, halfword or word) is accepted in IDLE. The
// alignment check is done at acceptance, and a legal access is then moved
// one byte per cycle. The most significant byte goes to the lowest address,
// so the bytes are stored big-endian. A load is assembled in a shift
// register and sign- or zero-extended to 32 bits on its final beat.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   req        request valid; the pipeline holds it until it is accepted
//   we         1 = store, 0 = load
//   size       00 byte, 01 halfword, 10 word, 11 illegal
//   sign_ext   loads only: 1 = sign-extend, 0 = zero-extend
//   addr       byte address of the access
//   wdata      store data; the low 1/2/4 bytes are used
//   busy       a transfer is in progress (the pipeline stalls)
//   done       one-cycle completion pulse
//   misalign   one-cycle alignment-error pulse, coincident with done
//   rdata      last completed load result, held until the next load
//   mem_read   memory read enable
//   mem_write  memory write enable (one byte per rising edge)
//   mem_addr   memory byte address
//   mem_wdata  store byte
//   mem_rdata  read byte, combinational from mem_addr

module mem_byte_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [31:0]       rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t state, state_next;

    // Request captured at acceptance
    logic              we_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    // Beat sequencing: beat_q counts up to last_q, which is N-1
    logic [1:0]        beat_q;
    logic [1:0]        last_q;

    // Load assembly shift register
    logic [31:0]       acc_q;

    // Combinational helpers
    logic              accept;
    logic              bad_align;
    logic              last_beat;
    logic [1:0]        byte_sel;
    logic [31:0]       acc_next;
    logic [31:0]       load_result;

    // Index of the final beat for each access size. The illegal size maps to
    // 0, but it never reaches XFER because the alignment check rejects it.
    function automatic logic [1:0] size_to_last(input logic [1:0] sz);
        logic [1:0] r;
        case (sz)
            2'b00:   r = 2'd0;
            2'b01:   r = 2'd1;
            2'b10:   r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Acceptance, alignment check and load-result formation
    always_comb begin
        accept    = (state == IDLE) && req;
        bad_align = ((size == 2'b01) && addr[0])
                 || ((size == 2'b10) && (addr[1:0] != 2'b00))
                 ||  (size == 2'b11);
        last_beat = (state == XFER) && (beat_q == last_q);

        // The shift happens at the edge that ends the beat. The result is
        // formed from this post-shift value, so the extension bit is taken
        // from the final assembled data.
        acc_next  = {acc_q[23:0], mem_rdata};

        load_result = acc_next;
        case (size_q)
            2'b00:   load_result = {{24{sign_q & acc_next[7]}},  acc_next[7:0]};
            2'b01:   load_result = {{16{sign_q & acc_next[15]}}, acc_next[15:0]};
            default: load_result = acc_next;
        endcase
    end

    // Next-state logic and memory-port outputs. All memory outputs are
    // forced to zero outside XFER.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 8'h00;
        // Stores send byte N-1-i on beat i, so the MSB goes out first
        byte_sel   = last_q - beat_q;

        case (state)
            IDLE: begin
                if (accept && !bad_align) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                busy      = 1'b1;
                mem_read  = ~we_q;
                mem_write = we_q;
                // The address is allowed to wrap modulo 2^ADDR_W
                mem_addr  = addr_q + {{(ADDR_W-2){1'b0}}, beat_q};
                case (byte_sel)
                    2'd0:    mem_wdata = wdata_q[7:0];
                    2'd1:    mem_wdata = wdata_q[15:8];
                    2'd2:    mem_wdata = wdata_q[23:16];
                    default: mem_wdata = wdata_q[31:24];
                endcase
                if (last_beat) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and datapath. done and misalign default low every
    // cycle, so each is a single-cycle pulse. The done cycle is IDLE, so a
    // new request can be accepted back to back. A reset during XFER simply
    // drops the transfer without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            sign_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            beat_q   <= 2'd0;
            last_q   <= 2'd0;
            acc_q    <= 32'h0;
            rdata    <= 32'h0;
            done     <= 1'b0;
            misalign <= 1'b0;
        end else begin
            state    <= state_next;
            done     <= 1'b0;
            misalign <= 1'b0;

            if (accept) begin
                we_q    <= we;
                size_q  <= size;
                sign_q  <= sign_ext;
                addr_q  <= addr;
                wdata_q <= wdata;
                beat_q  <= 2'd0;
                last_q  <= size_to_last(size);
                acc_q   <= 32'h0;
                // A rejected request completes immediately and never
                // touches memory or rdata
                if (bad_align) begin
                    done     <= 1'b1;
                    misalign <= 1'b1;
                end
            end

            if (state == XFER) begin
                if (!we_q) begin
                    acc_q <= acc_next;
                end
                if (last_beat) begin
                    done <= 1'b1;
                    if (!we_q) begin
                        rdata <= load_result;
                    end
                end else begin
                    beat_q <= beat_q + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_lsu.sv
// Testbench for mem_byte_lsu. Each directed request pushes its expected
// completion (cycle of done, misalign flag, rdata) into a scoreboard queue.
// A monitor pops and compares an entry whenever done is seen. A byte-wide
// memory model services the memory port and logs every access.

module tb_mem_byte_lsu;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        misalign;
    logic [31:0] rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    mem_byte_lsu #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .misalign  (misalign),
        .rdata     (rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        string       name;
        int          cyc;
        logic        mis;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] log_addr[$];
    logic [7:0]  log_data[$];
    logic        log_we[$];

    logic [7:0]  mem [256] = '{default: 8'h00};
    int          cyc = 0;
    int          busy_cnt = 0;
    int          total = 0;
    int          passed = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: 256 bytes addressed by the low address byte
    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    end

    // Access logger and busy-cycle counter
    always @(negedge clk) begin
        if (busy) busy_cnt <= busy_cnt + 1;
        if (mem_read || mem_write) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_write ? mem_wdata : mem_rdata);
            log_we.push_back(mem_write);
        end
    end

    task automatic checkOutput(input string nm, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput({e.name, "_done_cycle"}, cyc, e.cyc);
                checkOutput({e.name, "_misalign"}, {31'd0, misalign}, {31'd0, e.mis});
                checkOutput({e.name, "_rdata"}, rdata, e.rd);
            end
        end else if (misalign) begin
            checkOutput("misalign_without_done", 32'd1, 32'd0);
        end
    end

    // Present one request at the current negedge and hold req until the done
    // cycle. It returns at the negedge of the done cycle with req still high,
    // so the caller can chain a back-to-back request or drop req.
    task automatic applyStimulus(input string nm, input logic w,
                                 input logic [1:0] sz, input logic sx,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic mis, input logic [31:0] exp_rd);
        int p;
        int lat;
        int lb;
        int bb;
        req      = 1'b1;
        we       = w;
        size     = sz;
        sign_ext = sx;
        addr     = a;
        wdata    = wd;
        lat = mis ? 0 : ((sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4);
        @(posedge clk);
        #1;
        p  = cyc;
        lb = log_addr.size();
        bb = busy_cnt;
        sb_q.push_back('{name: nm, cyc: p + lat, mis: mis, rd: exp_rd});
        @(negedge clk);
        while (cyc < p + lat) @(negedge clk);
        checkOutput({nm, "_mem_beats"}, log_addr.size() - lb, lat);
        checkOutput({nm, "_busy_cycles"}, busy_cnt - bb, lat);
    endtask

    task automatic goIdle(input int n);
        req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int b;
        int p;
        rst_n    = 1'b0;
        req      = 1'b0;
        we       = 1'b0;
        size     = 2'b00;
        sign_ext = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset_rdata", rdata, 32'h0);
        checkOutput("reset_mem_addr", mem_addr, 32'h0);
        checkOutput("reset_ctrl", {19'd0, busy, done, misalign, mem_read, mem_write, mem_wdata},
                    32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Store word, MSB first at the lowest address
        applyStimulus("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hAABBCCDD, 1'b0, 32'h0);
        goIdle(1);
        checkOutput("mem_10", {24'd0, mem[8'h10]}, 32'hAA);
        checkOutput("mem_11", {24'd0, mem[8'h11]}, 32'hBB);
        checkOutput("mem_12", {24'd0, mem[8'h12]}, 32'hCC);
        checkOutput("mem_13", {24'd0, mem[8'h13]}, 32'hDD);

        // Loads of every size and extension
        applyStimulus("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hAABBCCDD);
        goIdle(1);
        applyStimulus("lb_10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, 32'hFFFFFFAA);
        goIdle(1);
        applyStimulus("lbu_10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 32'h000000AA);
        goIdle(1);
        applyStimulus("lh_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFFCCDD);
        goIdle(1);
        applyStimulus("lhu_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'h0000CCDD);
        goIdle(1);
        applyStimulus("lh_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 32'hFFFFAABB);
        goIdle(1);
        applyStimulus("lb_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDD);
        goIdle(1);

        // Misaligned and illegal requests: no memory traffic, rdata held
        applyStimulus("lw_11_mis", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b1, 32'hFFFFFFDD);
        goIdle(1);
        applyStimulus("lh_13_mis", 1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 1'b1, 32'hFFFFFFDD);
        goIdle(1);
        applyStimulus("size11_mis", 1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, 1'b1, 32'hFFFFFFDD);
        goIdle(1);
        checkOutput("mem_10_after_mis", {24'd0, mem[8'h10]}, 32'hAA);

        // Halfword with a clear sign bit: signed and unsigned loads agree
        applyStimulus("sh_50", 1'b1, 2'b01, 1'b0, 32'h50, 32'h99995566, 1'b0, 32'hFFFFFFDD);
        goIdle(1);
        applyStimulus("lh_50", 1'b0, 2'b01, 1'b1, 32'h50, 32'h0, 1'b0, 32'h00005566);
        goIdle(1);

        // Reset asserted at the edge that ends beat 1 of a word store
        req      = 1'b1;
        we       = 1'b1;
        size     = 2'b10;
        sign_ext = 1'b0;
        addr     = 32'h20;
        wdata    = 32'h11223344;
        @(posedge clk);
        #1;
        p = cyc;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_cycle", cyc, p + 2);
        checkOutput("rst_mid_rdata", rdata, 32'h0);
        checkOutput("rst_mid_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mid_ctrl", {19'd0, busy, done, misalign, mem_read, mem_write, mem_wdata},
                    32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_mem_20", {24'd0, mem[8'h20]}, 32'h11);
        checkOutput("rst_mem_21", {24'd0, mem[8'h21]}, 32'h22);
        checkOutput("rst_mem_22", {24'd0, mem[8'h22]}, 32'h00);
        checkOutput("rst_mem_23", {24'd0, mem[8'h23]}, 32'h00);

        applyStimulus("sb_30", 1'b1, 2'b00, 1'b0, 32'h30, 32'hCAFE0077, 1'b0, 32'h0);
        goIdle(1);
        checkOutput("mem_30", {24'd0, mem[8'h30]}, 32'h77);
        applyStimulus("lbu_30", 1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 1'b0, 32'h00000077);
        goIdle(1);

        // Back-to-back byte stores with req held high
        applyStimulus("sb_40", 1'b1, 2'b00, 1'b0, 32'h40, 32'h000000A1, 1'b0, 32'h00000077);
        applyStimulus("sb_41", 1'b1, 2'b00, 1'b0, 32'h41, 32'h000000B2, 1'b0, 32'h00000077);
        goIdle(1);
        checkOutput("mem_40", {24'd0, mem[8'h40]}, 32'hA1);
        checkOutput("mem_41", {24'd0, mem[8'h41]}, 32'hB2);

        // Word at the top of the address space
        b = log_addr.size();
        applyStimulus("sw_top", 1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h01020304, 1'b0,
                      32'h00000077);
        goIdle(1);
        if (log_addr.size() >= b + 4) begin
            checkOutput("top_addr0", log_addr[b],     32'hFFFFFFFC);
            checkOutput("top_addr1", log_addr[b + 1], 32'hFFFFFFFD);
            checkOutput("top_addr2", log_addr[b + 2], 32'hFFFFFFFE);
            checkOutput("top_addr3", log_addr[b + 3], 32'hFFFFFFFF);
            checkOutput("top_data0", {24'd0, log_data[b]},     32'h01);
            checkOutput("top_data3", {24'd0, log_data[b + 3]}, 32'h04);
            checkOutput("top_we", {28'd0, log_we[b], log_we[b + 1], log_we[b + 2], log_we[b + 3]},
                        32'hF);
        end else begin
            checkOutput("top_log_len", log_addr.size() - b, 4);
        end
        applyStimulus("lw_top", 1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b0, 32'h01020304);
        goIdle(1);
        applyStimulus("lbu_top", 1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h00000004);
        goIdle(3);

        checkOutput("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
